otp_stream_cypher: RTL and testbench

OTP_STREAM_CYPHER -- requirements
Module: otp_stream_cypher

---
 rtl/otp_stream_cypher.sv | 199 +++++++++++++++++++
 tb/tb_otp_stream_cypher.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/otp_stream_cypher.sv
// -----------------------------------------------------------------------------
// otp_stream_cypher
//
// Byte-serial XOR stream cypher. A start request latches the message and the
// key. The block then combines one message byte per cycle with the next
// keystream byte, beginning at byte 0 (the most significant byte). After
// MSG_BYTES cycles the complete result is copied into `out` in a single cycle,
// and `done` pulses. The transform is its own inverse: running `out` back
// through with the same key returns the original message.
//
// The keystream is the key repeated byte by byte. When fewer message bytes
// than key bytes exist, the extra key bytes are never reached.
//
// Optional feature, macro OTP_PASS_TWEAK_EN:
//   When defined, each keystream byte is also XORed with a pass counter. The
//   counter holds the number of complete trips through the key (mod 256) and
//   restarts at 0 on every start. When undefined, no pass counter is built.
//
// Ports:
//   clk    in   1            single clock, rising edge
//   rst    in   1            synchronous, active-high reset
//   start  in   1            process request, sampled every cycle (ignored in RUN)
//   msg    in   8*MSG_BYTES  plaintext/ciphertext, byte 0 = MSB
//   key    in   8*KEY_BYTES  key, key byte 0 = MSB
//   busy   out  1            high while in RUN
//   done   out  1            one-cycle pulse in DONE, out holds a new result
//   out    out  8*MSG_BYTES  result register, byte 0 = MSB
// -----------------------------------------------------------------------------
module otp_stream_cypher #(
  parameter int MSG_BYTES = 30,
  parameter int KEY_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8*MSG_BYTES-1:0] msg,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic                   busy,
  output logic                   done,
  output logic [8*MSG_BYTES-1:0] out
);

  localparam int MSG_W = 8 * MSG_BYTES;
  localparam int KEY_W = 8 * KEY_BYTES;
  localparam int IDX_W = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_BYTES - 1);
`ifdef OTP_PASS_TWEAK_EN
  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // The operand registers shift instead of being indexed. The byte being
  // processed is therefore always the top byte of msg_p0 and key_p0. The key
  // rotates, so after KEY_BYTES steps it wraps back to key byte 0.
  logic [MSG_W-1:0] msg_p0;
  logic [KEY_W-1:0] key_p0;
  logic [MSG_W-1:0] acc_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [MSG_W-1:0] out_p1;
`ifdef OTP_PASS_TWEAK_EN
  logic [KIDX_W-1:0] kidx_p0;
  logic [7:0]        pass_p0;
`endif

  logic             load;
  logic             step_en;
  logic             last_byte;
  logic [7:0]       ks_byte;
  logic [7:0]       res_byte;
  logic [MSG_W-1:0] acc_next;

  // Rotate left by one byte. When KEY_W == 8, the left shift yields zero and
  // the right shift is by zero, so a one-byte key stays put, which is correct.
  function automatic logic [KEY_W-1:0] rotl_byte(input logic [KEY_W-1:0] v);
    return (v << 8) | (v >> (KEY_W - 8));
  endfunction

  // Append a byte at the bottom of the accumulator. Earlier bytes move toward
  // the MSB, so after MSG_BYTES appends, byte 0 sits in the MSB position.
  function automatic logic [MSG_W-1:0] shift_in_byte(input logic [MSG_W-1:0] v,
                                                     input logic [7:0]       b);
    logic [MSG_W-1:0] ext;
    ext      = '0;
    ext[7:0] = b;
    return (v << 8) | ext;
  endfunction

  function automatic logic [7:0] cypher_byte(input logic [7:0] m, input logic [7:0] k);
    return m ^ k;
  endfunction

  // ---------------------------------------------------------------------------
  // Control: state register and next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          load    = 1'b1;
        end
      end
      S_RUN: begin
        step_en = 1'b1;
        if (last_byte) state_d = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          load    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign out  = out_p1;

  // ---------------------------------------------------------------------------
  // Stage p0: latched operands, byte index and result accumulator
  // ---------------------------------------------------------------------------
  assign last_byte = (idx_p0 == IDX_LAST);

`ifdef OTP_PASS_TWEAK_EN
  assign ks_byte = key_p0[KEY_W-1 -: 8] ^ pass_p0;
`else
  assign ks_byte = key_p0[KEY_W-1 -: 8];
`endif

  assign res_byte = cypher_byte(msg_p0[MSG_W-1 -: 8], ks_byte);
  assign acc_next = shift_in_byte(acc_p0, res_byte);

  always_ff @(posedge clk) begin
    if (rst) begin
      msg_p0 <= '0;
      key_p0 <= '0;
      acc_p0 <= '0;
      idx_p0 <= '0;
    end else if (load) begin
      msg_p0 <= msg;
      key_p0 <= key;
      acc_p0 <= '0;
      idx_p0 <= '0;
    end else if (step_en) begin
      msg_p0 <= msg_p0 << 8;
      key_p0 <= rotl_byte(key_p0);
      acc_p0 <= acc_next;
      idx_p0 <= idx_p0 + IDX_W'(1);
    end
  end

`ifdef OTP_PASS_TWEAK_EN
  // kidx_p0 tracks the position within the rotating key. Each time it wraps,
  // one full pass through the key has completed.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      kidx_p0 <= '0;
      pass_p0 <= '0;
    end else if (step_en) begin
      if (kidx_p0 == KIDX_LAST) begin
        kidx_p0 <= '0;
        pass_p0 <= pass_p0 + 8'd1;
      end else begin
        kidx_p0 <= kidx_p0 + KIDX_W'(1);
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Stage p1: result register, loaded whole on the final byte of a run
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst)                        out_p1 <= '0;
    else if (step_en && last_byte)  out_p1 <= acc_next;
  end

endmodule

// File: tb/tb_otp_stream_cypher.sv
module tb_otp_stream_cypher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         start_a, busy_a, done_a;
  logic [39:0]  msg_a, out_a;
  logic [15:0]  key_a;

  logic         start_b, busy_b, done_b;
  logic [239:0] msg_b, out_b;
  logic [15:0]  key_b;

  logic         start_c, busy_c, done_c;
  logic [39:0]  msg_c, out_c;
  logic [63:0]  key_c;

  otp_stream_cypher #(.MSG_BYTES(5), .KEY_BYTES(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .msg(msg_a), .key(key_a),
    .busy(busy_a), .done(done_a), .out(out_a));

  otp_stream_cypher u_b (
    .clk(clk), .rst(rst), .start(start_b), .msg(msg_b), .key(key_b),
    .busy(busy_b), .done(done_b), .out(out_b));

  otp_stream_cypher #(.MSG_BYTES(5), .KEY_BYTES(8)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .msg(msg_c), .key(key_c),
    .busy(busy_c), .done(done_c), .out(out_c));

  int total = 0;
  int bad   = 0;

  int lat, bn, dn, done_at;
  logic [239:0] m1, m2, r;
  logic [15:0]  k1, k2;
  logic [63:0]  k64;
  logic [39:0]  exp_hello;
  logic [39:0]  first_out;

  task automatic check(input string tag, input logic [239:0] obs, input logic [239:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: out byte i = msg byte i XOR key byte (i mod nk), optionally
  // XOR (i / nk) mod 256. Operands are right-aligned, byte 0 is the top byte.
  function automatic logic [239:0] ref_cypher(input logic [239:0] m, input logic [63:0] k,
                                              input int nm, input int nk);
    logic [239:0] res;
    logic [7:0]   kb;
    res = '0;
    for (int i = 0; i < nm; i++) begin
      kb = k[8*(nk-1-(i % nk)) +: 8];
`ifdef OTP_PASS_TWEAK_EN
      kb = kb ^ 8'((i / nk) % 256);
`endif
      res[8*(nm-1-i) +: 8] = m[8*(nm-1-i) +: 8] ^ kb;
    end
    return res;
  endfunction

  function automatic logic [239:0] rand_bits();
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom();
    return v[239:0];
  endfunction

  // Called just after the start edge; counts busy cycles until done, bounded.
  task automatic run_wait(input int sel, output int lat_o, output int busy_o, output int done_o);
    logic b, d;
    lat_o = 0; busy_o = 0; done_o = 0;
    for (int c = 0; c < 100; c++) begin
      case (sel)
        0:       b = busy_a;
        1:       b = busy_b;
        default: b = busy_c;
      endcase
      if (b) busy_o++;
      step();
      lat_o++;
      case (sel)
        0:       d = done_a;
        1:       d = done_b;
        default: d = done_c;
      endcase
      if (d) begin
        done_o++;
        break;
      end
    end
  endtask

  initial begin
`ifdef OTP_PASS_TWEAK_EN
    exp_hello = 40'h49466C4E6C;
`else
    exp_hello = 40'h49466D4F6E;
`endif
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    msg_a = '0; key_a = '0; msg_b = '0; key_b = '0; msg_c = '0; key_c = '0;
    step(); step();
    check("rst_busy_a", 240'(busy_a), '0);
    check("rst_done_a", 240'(done_a), '0);
    check("rst_out_a", 240'(out_a), '0);
    check("rst_busy_b", 240'(busy_b), '0);
    check("rst_out_b", out_b, '0);
    check("rst_out_c", 240'(out_c), '0);

    // Reset wins over start in the same cycle.
    msg_a = 40'h48656C6C6F; key_a = 16'h0123;
    rst = 1'b1; start_a = 1'b1;
    step();
    rst = 1'b0; start_a = 1'b0;
    check("rst_over_start", 240'(busy_a), '0);
    step();
    check("rst_over_start_idle", 240'(busy_a), '0);

    // "Hello" example.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check("hello_busy", 240'(busy_a), 240'(1));
    check("hello_no_partial", 240'(out_a), '0);
    run_wait(0, lat, bn, dn);
    check("hello_latency", 240'(lat), 240'(5));
    check("hello_busy_cycles", 240'(bn), 240'(5));
    check("hello_out", 240'(out_a), 240'(exp_hello));
    step();
    check("hello_done_one_cycle", 240'(done_a), '0);
    check("hello_out_held", 240'(out_a), 240'(exp_hello));

    // Round trip returns the plaintext.
    msg_a = out_a;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    run_wait(0, lat, bn, dn);
    check("hello_roundtrip", 240'(out_a), 240'(40'h48656C6C6F));

    // Default size: start held three cycles gives one run; restart in DONE.
    m1 = rand_bits(); msg_b = m1; key_b = 16'h0123; start_b = 1'b1;
    bn = 0; dn = 0; done_at = -1;
    for (int c = 1; c <= 31; c++) begin
      step();
      if (c == 3) start_b = 1'b0;
      if (busy_b) bn++;
      if (done_b) begin
        dn++;
        done_at = c - 1;
      end
    end
    check("b_busy_cycles", 240'(bn), 240'(30));
    check("b_done_count", 240'(dn), 240'(1));
    check("b_done_at", 240'(done_at), 240'(30));
    check("b_out1", out_b, ref_cypher(m1, 64'(16'h0123), 30, 2));
    m2 = rand_bits(); msg_b = m2; start_b = 1'b1;
    step();
    start_b = 1'b0;
    check("b_no_gap_busy", 240'(busy_b), 240'(1));
    check("b_no_gap_done", 240'(done_b), '0);
    check("b_out1_held", out_b, ref_cypher(m1, 64'(16'h0123), 30, 2));
    run_wait(1, lat, bn, dn);
    check("b_latency2", 240'(lat), 240'(30));
    check("b_busy2", 240'(bn), 240'(30));
    check("b_out2", out_b, ref_cypher(m2, 64'(16'h0123), 30, 2));

    // Key longer than message: only the first five key bytes matter.
    r = rand_bits(); msg_c = r[39:0]; key_c = 64'h0102030405060708;
    start_c = 1'b1;
    step();
    start_c = 1'b0;
    run_wait(2, lat, bn, dn);
    check("c_latency", 240'(lat), 240'(5));
    check("c_out", 240'(out_c), 240'(r[39:0] ^ 40'h0102030405));

    // Reset in the third RUN cycle aborts the run.
    r = rand_bits(); msg_a = r[39:0]; key_a = 16'hBEEF;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 240'(busy_a), '0);
    check("abort_done", 240'(done_a), '0);
    check("abort_out", 240'(out_a), '0);
    dn = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (done_a) dn++;
    end
    check("abort_no_done", 240'(dn), '0);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    run_wait(0, lat, bn, dn);
    check("after_abort_latency", 240'(lat), 240'(5));
    check("after_abort_out", 240'(out_a), ref_cypher(240'(r[39:0]), 64'(16'hBEEF), 5, 2));

    // Start during RUN is ignored, not queued.
    r = rand_bits(); k1 = 16'($urandom()); msg_a = r[39:0]; key_a = k1;
    m1 = 240'(r[39:0]);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    step(); step();
    r = rand_bits(); msg_a = r[39:0]; key_a = 16'($urandom());
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    run_wait(0, lat, bn, dn);
    check("ignore_start_latency", 240'(lat), 240'(2));
    check("ignore_start_out", 240'(out_a), ref_cypher(m1, 64'(k1), 5, 2));
    step();
    check("ignore_start_not_queued", 240'(busy_a), '0);

    // Inputs churning during RUN do not affect the result.
    r = rand_bits(); k1 = 16'($urandom()); msg_a = r[39:0]; key_a = k1;
    m1 = 240'(r[39:0]);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 0; c < 5; c++) begin
      r = rand_bits(); msg_a = r[39:0]; key_a = 16'($urandom());
      step();
    end
    check("churn_done", 240'(done_a), 240'(1));
    check("churn_out", 240'(out_a), ref_cypher(m1, 64'(k1), 5, 2));

    // Random runs with round trips, plus long-key instance.
    for (int it = 0; it < 6; it++) begin
      r = rand_bits(); k2 = 16'($urandom()); msg_a = r[39:0]; key_a = k2;
      m2 = 240'(r[39:0]);
      r = rand_bits(); msg_c = r[39:0];
      k64 = {$urandom(), $urandom()}; key_c = k64;
      m1 = 240'(r[39:0]);
      start_a = 1'b1; start_c = 1'b1;
      step();
      start_a = 1'b0; start_c = 1'b0;
      run_wait(0, lat, bn, dn);
      check("rnd_a_latency", 240'(lat), 240'(5));
      check("rnd_a_out", 240'(out_a), ref_cypher(m2, 64'(k2), 5, 2));
      check("rnd_c_out", 240'(out_c), ref_cypher(m1, k64, 5, 8));
      first_out = out_a;
      msg_a = first_out;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      run_wait(0, lat, bn, dn);
      check("rnd_a_roundtrip", 240'(out_a), m2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
